// File: rtl/fflags_accumulator.sv
// Buffers retired FPU exception flags and merges them into FFLAGS through the shared CSR write port.
// Optional macro FFLAGS_COALESCE_EN: each drain writes the OR of all pending entries and empties the FIFO.
module fflags_accumulator #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_fp_valid,
  input  logic [4:0]      i_fp_flags,
  output logic            o_fp_ready,
  input  logic            i_core_req,
  input  logic [11:0]     i_core_addr,
  input  logic [1:0]      i_core_op,
  input  logic            i_core_write,
  input  logic [XLEN-1:0] i_core_wdata,
  output logic            o_core_gnt,
  output logic [11:0]     o_csr_addr,
  output logic [1:0]      o_csr_op,
  output logic            o_csr_write,
  output logic [XLEN-1:0] o_wr_data,
  output logic            o_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state;
  logic [4:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          fflags_hit;
  logic          push;
  logic          store;
  logic          pop;
  logic [4:0]    head_flags;

  assign fflags_hit = i_core_req && ((i_core_addr == 12'h001) || (i_core_addr == 12'h003));
  assign o_fp_ready = (count != CW'(DEPTH)) && (state != FLUSH);
  assign push       = i_fp_valid && o_fp_ready;
  assign store      = push && (i_fp_flags != 5'd0);
  assign o_busy     = (count != '0);

  // Core wins the port unless it touches fflags; then pending flags drain first.
  always_comb begin
    o_core_gnt = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE:    o_core_gnt = i_core_req;
      DRAIN: begin
        if (i_core_req && !fflags_hit) o_core_gnt = 1'b1;
        else                           pop        = 1'b1;
      end
      FLUSH:   pop = 1'b1;
      default: ;
    endcase
    if (count == '0) pop = 1'b0;
  end

  always_comb begin
    head_flags = '0;
`ifdef FFLAGS_COALESCE_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) head_flags = head_flags | mem[head + PW'(i)];
    end
    count_next = pop ? CW'(store) : count + CW'(store);
`else
    head_flags = mem[head];
    count_next = count - CW'(pop) + CW'(store);
`endif
  end

  always_comb begin
    o_csr_addr  = '0;
    o_csr_op    = '0;
    o_csr_write = 1'b0;
    o_wr_data   = '0;
    if (o_core_gnt) begin
      o_csr_addr  = i_core_addr;
      o_csr_op    = i_core_op;
      o_csr_write = i_core_write;
      o_wr_data   = i_core_wdata;
    end else if (pop) begin
      o_csr_addr     = 12'h001;
      o_csr_op       = 2'b01;
      o_csr_write    = 1'b1;
      o_wr_data[4:0] = head_flags;
    end
  end

  // Flag storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (store) mem[tail] <= i_fp_flags;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store) tail <= tail + PW'(1);
`ifdef FFLAGS_COALESCE_EN
      if (pop) head <= tail;
`else
      if (pop) head <= head + PW'(1);
`endif
      count <= count_next;
      case (state)
        IDLE: if (store) state <= DRAIN;
        DRAIN: begin
          if (count_next == '0)       state <= IDLE;
          else if (pop && fflags_hit) state <= FLUSH;
        end
        FLUSH: if (count_next == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fflags_accumulator.sv
// Self-checking bench for fflags_accumulator: directed scenarios plus a randomized run
// checked against a queue-based model of the flag buffer and CSR port arbitration.
module tb_fflags_accumulator;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef FFLAGS_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fp_valid;
  logic [4:0]      fp_flags;
  logic            fp_ready;
  logic            core_req;
  logic [11:0]     core_addr;
  logic [1:0]      core_op;
  logic            core_write;
  logic [XLEN-1:0] core_wdata;
  logic            core_gnt;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic            csr_write;
  logic [XLEN-1:0] wr_data;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] q[$];
  bit         flushing;

  fflags_accumulator #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fp_valid(fp_valid), .i_fp_flags(fp_flags), .o_fp_ready(fp_ready),
    .i_core_req(core_req), .i_core_addr(core_addr), .i_core_op(core_op),
    .i_core_write(core_write), .i_core_wdata(core_wdata),
    .o_core_gnt(core_gnt), .o_csr_addr(csr_addr), .o_csr_op(csr_op),
    .o_csr_write(csr_write), .o_wr_data(wr_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fp(input logic v, input logic [4:0] f);
    fp_valid = v;
    fp_flags = f;
  endtask

  task automatic set_core(input logic r, input logic [11:0] a, input logic [1:0] o,
                          input logic w, input logic [XLEN-1:0] d);
    core_req   = r;
    core_addr  = a;
    core_op    = o;
    core_write = w;
    core_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_fp(1'b0, 5'd0);
    set_core(1'b0, 12'h0, 2'b00, 1'b0, '0);
    #12;
    n_cmp++;
    if ({fp_ready, busy, csr_write, core_gnt} !== 4'b1000) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got ready/busy/write/gnt=%b expected 1000",
               {fp_ready, busy, csr_write, core_gnt});
    end
    n_cmp++;
    if ({csr_addr, csr_op, wr_data} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_fields: got addr=%h op=%h data=%h expected all 0", csr_addr, csr_op, wr_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_drain();
    set_fp(1'b1, 5'b00001);
    #2;
    n_cmp++;
    if (csr_write !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL push_cycle_write: got %b expected 0", csr_write);
    end
    tick();
    set_fp(1'b0, 5'd0);
    #2;
    n_cmp++;
    if ({csr_write, csr_addr, csr_op, wr_data, busy} !== {1'b1, 12'h001, 2'b01, 32'h1, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL single_drain: got write=%b addr=%h op=%b data=%h busy=%b expected 1 001 01 00000001 1",
               csr_write, csr_addr, csr_op, wr_data, busy);
    end
    tick();
    #2;
    n_cmp++;
    if ({busy, csr_write} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL single_after: got busy=%b write=%b expected 0 0", busy, csr_write);
    end
    tick();
  endtask

  task automatic test_full();
    logic [4:0] flags [4];
    flags = '{5'h01, 5'h02, 5'h04, 5'h08};
    set_core(1'b1, 12'h300, 2'b01, 1'b1, 32'h0000ABCD);
    for (int i = 0; i < 4; i++) begin
      set_fp(1'b1, flags[i]);
      #2;
      n_cmp++;
      if ({core_gnt, csr_addr, wr_data} !== {1'b1, 12'h300, 32'h0000ABCD}) begin
        n_err++;
        $display("[TB] FAIL full_pass%0d: got gnt=%b addr=%h data=%h expected 1 300 0000abcd",
                 i, core_gnt, csr_addr, wr_data);
      end
      tick();
    end
    set_fp(1'b1, 5'h10);
    #2;
    n_cmp++;
    if ({fp_ready, busy} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL full_ready: got ready=%b busy=%b expected 0 1", fp_ready, busy);
    end
    tick();
    set_fp(1'b1, 5'h10);
    set_core(1'b0, 12'h0, 2'b00, 1'b0, '0);
    #2;
    n_cmp++;
    if ({fp_ready, csr_write, wr_data} !== {1'b0, 1'b1, (COALESCE ? 32'h0F : 32'h01)}) begin
      n_err++;
      $display("[TB] FAIL full_first_pop: got ready=%b write=%b data=%h expected 0 1 %h",
               fp_ready, csr_write, wr_data, (COALESCE ? 32'h0F : 32'h01));
    end
    tick();
    set_fp(1'b0, 5'd0);
    #2;
    n_cmp++;
    if (fp_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL full_ready_back: got %b expected 1", fp_ready);
    end
    for (int i = 0; i < 8 && busy; i++) tick();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL full_drain_timeout: busy=%b expected 0 within 8 cycles", busy);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [4:0] flags [3];
    int nw;
    flags = '{5'h01, 5'h04, 5'h10};
    nw = COALESCE ? 1 : 3;
    set_core(1'b1, 12'h300, 2'b00, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      set_fp(1'b1, flags[i]);
      tick();
    end
    set_fp(1'b0, 5'd0);
    set_core(1'b1, 12'h003, 2'b01, 1'b0, 32'h55);
    for (int i = 0; i < nw; i++) begin
      #2;
      n_cmp++;
      if ({core_gnt, csr_write, csr_addr, wr_data} !==
          {1'b0, 1'b1, 12'h001, (COALESCE ? 32'h15 : {27'd0, flags[i]})}) begin
        n_err++;
        $display("[TB] FAIL flush_write%0d: got gnt=%b write=%b addr=%h data=%h", i, core_gnt, csr_write, csr_addr, wr_data);
      end
      if (i > 0) begin
        n_cmp++;
        if (fp_ready !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL flush_ready%0d: got %b expected 0", i, fp_ready);
        end
      end
      tick();
    end
    #2;
    n_cmp++;
    if ({core_gnt, csr_addr, csr_op, csr_write, wr_data, busy} !==
        {1'b1, 12'h003, 2'b01, 1'b0, 32'h55, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL flush_grant: got gnt=%b addr=%h op=%b write=%b data=%h busy=%b expected 1 003 01 0 00000055 0",
               core_gnt, csr_addr, csr_op, csr_write, wr_data, busy);
    end
    set_core(1'b0, 12'h0, 2'b00, 1'b0, '0);
    tick();
  endtask

  task automatic test_frm_pass();
    set_fp(1'b1, 5'h06);
    tick();
    set_fp(1'b0, 5'd0);
    set_core(1'b1, 12'h002, 2'b10, 1'b1, 32'h1F);
    #2;
    n_cmp++;
    if ({core_gnt, csr_addr, csr_op, csr_write, wr_data, busy} !==
        {1'b1, 12'h002, 2'b10, 1'b1, 32'h1F, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL frm_grant: got gnt=%b addr=%h op=%b write=%b data=%h busy=%b expected 1 002 10 1 0000001f 1",
               core_gnt, csr_addr, csr_op, csr_write, wr_data, busy);
    end
    tick();
    set_core(1'b0, 12'h0, 2'b00, 1'b0, '0);
    #2;
    n_cmp++;
    if ({csr_write, csr_addr, wr_data} !== {1'b1, 12'h001, 32'h06}) begin
      n_err++;
      $display("[TB] FAIL frm_after_drain: got write=%b addr=%h data=%h expected 1 001 00000006", csr_write, csr_addr, wr_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_core(1'b1, 12'h300, 2'b00, 1'b0, '0);
    set_fp(1'b1, 5'h03);
    tick();
    set_fp(1'b1, 5'h0C);
    tick();
    set_fp(1'b0, 5'd0);
    set_core(1'b0, 12'h0, 2'b00, 1'b0, '0);
    #1;
    n_cmp++;
    if ({busy, csr_write} !== 2'b11) begin
      n_err++;
      $display("[TB] FAIL mid_before_reset: got busy=%b write=%b expected 1 1", busy, csr_write);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, csr_write} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL mid_async_reset: got busy=%b write=%b expected 0 0", busy, csr_write);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if ({busy, csr_write} !== 2'b00) begin
        n_err++;
        $display("[TB] FAIL mid_post_reset%0d: got busy=%b write=%b expected 0 0", i, busy, csr_write);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [49:0] got, exp;
    logic        ff, e_gnt, e_drain, e_ready, start_flush;
    logic [4:0]  e_data;
    logic [11:0] addrs [5];
    addrs = '{12'h001, 12'h002, 12'h003, 12'h300, 12'hC00};
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    q.delete();
    flushing = 1'b0;
    for (int c = 0; c < 400; c++) begin
      set_fp($urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      set_core($urandom_range(0, 9) < 3, addrs[$urandom_range(0, 4)], 2'($urandom_range(0, 2)),
               1'($urandom), $urandom);
      ff          = core_req && (core_addr == 12'h001 || core_addr == 12'h003);
      e_ready     = !flushing && (q.size() < DEPTH);
      e_gnt       = 1'b0;
      e_drain     = 1'b0;
      start_flush = 1'b0;
      if (flushing)                 e_drain = 1'b1;
      else if (q.size() == 0)       e_gnt   = core_req;
      else if (core_req && !ff)     e_gnt   = 1'b1;
      else begin
        e_drain     = 1'b1;
        start_flush = ff;
      end
      e_data = 5'd0;
      if (e_drain) begin
        if (COALESCE) foreach (q[i]) e_data = e_data | q[i];
        else          e_data = q[0];
      end
      if (e_gnt)        exp = {1'b1, core_addr, core_op, core_write, core_wdata, e_ready, q.size() != 0};
      else if (e_drain) exp = {1'b0, 12'h001, 2'b01, 1'b1, {27'd0, e_data}, e_ready, 1'b1};
      else              exp = {1'b0, 12'h000, 2'b00, 1'b0, 32'd0, e_ready, q.size() != 0};
      #2;
      got = {core_gnt, csr_addr, csr_op, csr_write, wr_data, fp_ready, busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL random_c%0d: got {gnt,addr,op,wr,data,ready,busy}=%h expected %h", c, got, exp);
      end
      @(posedge clk);
      #1;
      if (e_drain) begin
        if (COALESCE) q.delete();
        else          void'(q.pop_front());
      end
      if (fp_valid && e_ready && fp_flags != 5'd0) q.push_back(fp_flags);
      if (start_flush) flushing = 1'b1;
      if (q.size() == 0) flushing = 1'b0;
    end
    set_fp(1'b0, 5'd0);
    set_core(1'b0, 12'h0, 2'b00, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_full();
    test_flush();
    test_frm_pass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
